// File: rtl/decode_stage.sv
// RISC-V base-opcode decode stage behind a two-entry skid buffer (OUT + SKID).
// Optional illegal-instruction checking is enabled by defining DECODE_ILLEGAL_CHECK_EN.
package decode_pkg;
  typedef struct packed {
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs2;
    logic [4:0]  rs1;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [11:0] imm_i;
    logic [11:0] imm_s;
    logic [12:0] imm_b;
    logic [19:0] imm_u;
    logic [20:0] imm_j;
  } instr_field;

  typedef struct packed {
    logic load;
    logic load_fp;
    logic misc_mem;
    logic op_imm;
    logic auipc;
    logic op_imm_32;
    logic store;
    logic store_fp;
    logic amo;
    logic op;
    logic lui;
    logic op_32;
    logic madd;
    logic msub;
    logic nmsub;
    logic nmadd;
    logic op_fp;
    logic branch;
    logic jalr;
    logic jal;
    logic system;
  } opcode_map;
endpackage

module decode_stage
  import decode_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC_TAG = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     in_instr_i,
  input  logic [XLEN-1:0] in_pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_pc_o,
  output instr_field      out_field_o,
  output opcode_map       out_op_o,
  output logic [XLEN-1:0] out_imm_o,
  output logic            out_illegal_o
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    instr_field      fld;
    opcode_map       op;
    logic [XLEN-1:0] imm;
  } entry_t;

  // Encoding chosen so that bit 0 is "OUT valid" and bit 1 is "SKID valid".
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b01,
    S_FULL  = 2'b11
  } state_e;

  state_e r_state;
  state_e w_state_nxt;
  entry_t r_out;
  entry_t r_skid;
  entry_t w_dec;
  logic   w_in_xfer;
  logic   w_out_xfer;
  logic   w_ld_out_in;
  logic   w_ld_out_skid;
  logic   w_ld_skid;

  // ---------------- decode (input side) ----------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    w_dec        = '0;
    w_dec.pc     = in_pc_i;
    w_dec.fld.funct7 = in_instr_i[31:25];
    w_dec.fld.funct3 = in_instr_i[14:12];
    w_dec.fld.rs2    = in_instr_i[24:20];
    w_dec.fld.rs1    = in_instr_i[19:15];
    w_dec.fld.rd     = in_instr_i[11:7];
    w_dec.fld.opcode = in_instr_i[6:0];
    w_dec.fld.imm_i  = in_instr_i[31:20];
    w_dec.fld.imm_s  = {in_instr_i[31:25], in_instr_i[11:7]};
    w_dec.fld.imm_b  = {in_instr_i[31], in_instr_i[7], in_instr_i[30:25], in_instr_i[11:8], 1'b0};
    w_dec.fld.imm_u  = in_instr_i[31:12];
    w_dec.fld.imm_j  = {in_instr_i[31], in_instr_i[19:12], in_instr_i[20], in_instr_i[30:21], 1'b0};

    if (in_instr_i[1:0] == 2'b11) begin
      case (in_instr_i[6:2])
        5'b00000: w_dec.op.load      = 1'b1;
        5'b00001: w_dec.op.load_fp   = 1'b1;
        5'b00011: w_dec.op.misc_mem  = 1'b1;
        5'b00100: w_dec.op.op_imm    = 1'b1;
        5'b00101: w_dec.op.auipc     = 1'b1;
        5'b00110: w_dec.op.op_imm_32 = 1'b1;
        5'b01000: w_dec.op.store     = 1'b1;
        5'b01001: w_dec.op.store_fp  = 1'b1;
        5'b01011: w_dec.op.amo       = 1'b1;
        5'b01100: w_dec.op.op        = 1'b1;
        5'b01101: w_dec.op.lui       = 1'b1;
        5'b01110: w_dec.op.op_32     = 1'b1;
        5'b10000: w_dec.op.madd      = 1'b1;
        5'b10001: w_dec.op.msub      = 1'b1;
        5'b10010: w_dec.op.nmsub     = 1'b1;
        5'b10011: w_dec.op.nmadd     = 1'b1;
        5'b10100: w_dec.op.op_fp     = 1'b1;
        5'b11000: w_dec.op.branch    = 1'b1;
        5'b11001: w_dec.op.jalr      = 1'b1;
        5'b11011: w_dec.op.jal       = 1'b1;
        5'b11100: w_dec.op.system    = 1'b1;
        default:  ;
      endcase
    end

    if (w_dec.op.load || w_dec.op.op_imm || w_dec.op.op_imm_32 || w_dec.op.jalr)
      w_dec.imm = XLEN'($signed(w_dec.fld.imm_i));
    else if (w_dec.op.store)
      w_dec.imm = XLEN'($signed(w_dec.fld.imm_s));
    else if (w_dec.op.branch)
      w_dec.imm = XLEN'($signed(w_dec.fld.imm_b));
    else if (w_dec.op.lui || w_dec.op.auipc)
      w_dec.imm = XLEN'($signed({w_dec.fld.imm_u, 12'b0}));
    else if (w_dec.op.jal)
      w_dec.imm = XLEN'($signed(w_dec.fld.imm_j));
  end

  // ---------------- skid-buffer control ----------------
  assign out_valid_o = (r_state != S_EMPTY);
  assign in_ready_o  = (r_state != S_FULL);
  assign w_in_xfer   = in_valid_i && in_ready_o;
  assign w_out_xfer  = out_valid_o && out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_ni) r_state <= S_EMPTY;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ld_out_in   = 1'b0;
    w_ld_out_skid = 1'b0;
    w_ld_skid     = 1'b0;
    if (flush_i) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_in_xfer) begin
          w_ld_out_in = 1'b1;
          w_state_nxt = S_ONE;
        end
        S_ONE: case ({w_in_xfer, w_out_xfer})
          2'b10: begin
            w_ld_skid   = 1'b1;
            w_state_nxt = S_FULL;
          end
          2'b11:   w_ld_out_in = 1'b1;
          2'b01:   w_state_nxt = S_EMPTY;
          default: ;
        endcase
        S_FULL: if (w_out_xfer) begin
          w_ld_out_skid = 1'b1;
          w_state_nxt   = S_ONE;
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: the two entry registers are reset too, so nothing stale is ever observable after reset.
    if (!rst_ni) begin
      r_out  <= '0;
      r_skid <= '0;
    end else begin
      if (w_ld_out_in)        r_out <= w_dec;
      else if (w_ld_out_skid) r_out <= r_skid;
      if (w_ld_skid)          r_skid <= w_dec;
    end
  end

  // Outputs are masked while OUT is empty so flushed/reset contents never leak.
  assign out_pc_o    = out_valid_o ? r_out.pc  : RESET_PC_TAG;
  assign out_field_o = out_valid_o ? r_out.fld : '0;
  assign out_op_o    = out_valid_o ? r_out.op  : '0;
  assign out_imm_o   = out_valid_o ? r_out.imm : '0;

`ifdef DECODE_ILLEGAL_CHECK_EN
  logic r_out_ill;
  logic r_skid_ill;
  logic w_dec_ill;

  assign w_dec_ill = (in_instr_i[1:0] != 2'b11) || (w_dec.op == '0) ||
                     ((XLEN == 32) && (w_dec.op.op_32 || w_dec.op.op_imm_32));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out_ill  <= 1'b0;
      r_skid_ill <= 1'b0;
    end else begin
      if (w_ld_out_in)        r_out_ill <= w_dec_ill;
      else if (w_ld_out_skid) r_out_ill <= r_skid_ill;
      if (w_ld_skid)          r_skid_ill <= w_dec_ill;
    end
  end

  assign out_illegal_o = out_valid_o && r_out_ill;
`else
  assign out_illegal_o = 1'b0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Randomized self-checking bench for decode_stage against a queue-based reference model.
// Honours DECODE_ILLEGAL_CHECK_EN the same way the design does.
module tb_decode_stage;
  import decode_pkg::*;

  localparam int              XLEN = 32;
  localparam logic [XLEN-1:0] TAG  = 32'hBAD0_0000;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            flush_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [31:0]     in_instr_i;
  logic [XLEN-1:0] in_pc_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] out_pc_o;
  instr_field      out_field_o;
  opcode_map       out_op_o;
  logic [XLEN-1:0] out_imm_o;
  logic            out_illegal_o;

  decode_stage #(.XLEN(XLEN), .RESET_PC_TAG(TAG)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_instr_i(in_instr_i), .in_pc_i(in_pc_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_pc_o(out_pc_o), .out_field_o(out_field_o), .out_op_o(out_op_o),
    .out_imm_o(out_imm_o), .out_illegal_o(out_illegal_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [XLEN-1:0] pc;
    instr_field      f;
    opcode_map       op;
    logic [XLEN-1:0] imm;
    logic            ill;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

`ifdef DECODE_ILLEGAL_CHECK_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Sign-adjusts an unsigned field value of the given bit width.
  function automatic longint sx(input longint v, input int bits);
    longint half = longint'(1) <<< (bits - 1);
    return (v >= half) ? v - (half * 2) : v;
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [XLEN-1:0] pc);
    exp_t   e;
    longint v = 0;
    e.pc       = pc;
    e.f.funct7 = ins[31:25];
    e.f.funct3 = ins[14:12];
    e.f.rs2    = ins[24:20];
    e.f.rs1    = ins[19:15];
    e.f.rd     = ins[11:7];
    e.f.opcode = ins[6:0];
    e.f.imm_i  = ins[31:20];
    e.f.imm_s  = {ins[31:25], ins[11:7]};
    e.f.imm_b  = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    e.f.imm_u  = ins[31:12];
    e.f.imm_j  = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    e.op = '0;
    case (ins[6:0])
      7'h03: e.op.load      = 1'b1;
      7'h07: e.op.load_fp   = 1'b1;
      7'h0F: e.op.misc_mem  = 1'b1;
      7'h13: e.op.op_imm    = 1'b1;
      7'h17: e.op.auipc     = 1'b1;
      7'h1B: e.op.op_imm_32 = 1'b1;
      7'h23: e.op.store     = 1'b1;
      7'h27: e.op.store_fp  = 1'b1;
      7'h2F: e.op.amo       = 1'b1;
      7'h33: e.op.op        = 1'b1;
      7'h37: e.op.lui       = 1'b1;
      7'h3B: e.op.op_32     = 1'b1;
      7'h43: e.op.madd      = 1'b1;
      7'h47: e.op.msub      = 1'b1;
      7'h4B: e.op.nmsub     = 1'b1;
      7'h4F: e.op.nmadd     = 1'b1;
      7'h53: e.op.op_fp     = 1'b1;
      7'h63: e.op.branch    = 1'b1;
      7'h67: e.op.jalr      = 1'b1;
      7'h6F: e.op.jal       = 1'b1;
      7'h73: e.op.system    = 1'b1;
      default: ;
    endcase
    case (ins[6:0])
      7'h03, 7'h13, 7'h1B, 7'h67: v = sx(longint'(ins[31:20]), 12);
      7'h23: v = sx(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12);
      7'h63: v = sx(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
                    longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
      7'h37, 7'h17: v = sx(longint'(ins[31:12]) * 4096, 32);
      7'h6F: v = sx(longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096 +
                    longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
      default: v = 0;
    endcase
    e.imm = v[XLEN-1:0];
    e.ill = ILL_EN && ((ins[1:0] != 2'b11) || (e.op == '0) ||
                       ((XLEN == 32) && (e.op.op_32 || e.op.op_imm_32)));
    return e;
  endfunction

  // One cycle: drive inputs, compare outputs with the model, advance the model, clock.
  task automatic step(input bit v, input logic [31:0] ins, input logic [XLEN-1:0] pc,
                      input bit ordy, input bit fl, output bit acc);
    bit exp_rdy, exp_vld;
    in_valid_i  = v;
    in_instr_i  = ins;
    in_pc_i     = pc;
    out_ready_i = ordy;
    flush_i     = fl;
    exp_rdy = (q.size() < 2);
    exp_vld = (q.size() > 0);
    check("in_ready", 128'(in_ready_o), 128'(exp_rdy));
    check("out_valid", 128'(out_valid_o), 128'(exp_vld));
    if (exp_vld) begin
      check("out_pc", 128'(out_pc_o), 128'(q[0].pc));
      check("out_imm", 128'(out_imm_o), 128'(q[0].imm));
      check("out_field", 128'(out_field_o), 128'(q[0].f));
      check("out_op", 128'(out_op_o), 128'(q[0].op));
      check("out_illegal", 128'(out_illegal_o), 128'(q[0].ill));
    end else begin
      check("idle_pc", 128'(out_pc_o), 128'(TAG));
      check("idle_op", 128'(out_op_o), 128'(0));
    end
    acc = v && exp_rdy && !fl;
    if (fl) q.delete();
    else begin
      if (exp_vld && ordy) void'(q.pop_front());
      if (v && exp_rdy) q.push_back(model(ins, pc));
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, '0, 1'b1, 1'b0, acc);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 128'(out_valid_o), 128'(0));
    check({tag, "_ready"}, 128'(in_ready_o), 128'(1));
    check({tag, "_pc"}, 128'(out_pc_o), 128'(TAG));
    check({tag, "_imm"}, 128'(out_imm_o), 128'(0));
    check({tag, "_op"}, 128'(out_op_o), 128'(0));
    check({tag, "_field"}, 128'(out_field_o), 128'(0));
    check({tag, "_illegal"}, 128'(out_illegal_o), 128'(0));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [21] = '{7'h03, 7'h07, 7'h0F, 7'h13, 7'h17, 7'h1B, 7'h23,
                              7'h27, 7'h2F, 7'h33, 7'h37, 7'h3B, 7'h43, 7'h47,
                              7'h4B, 7'h4F, 7'h53, 7'h63, 7'h67, 7'h6F, 7'h73};
    logic [31:0] r = $urandom();
    if ($urandom_range(0, 7) == 0) return r;
    return {r[31:7], ops[$urandom_range(0, 20)]};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit              acc;
    bit              have;
    logic [31:0]     pi;
    logic [XLEN-1:0] ppc;
    int              tries;

    rst_ni = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    in_instr_i = '0; in_pc_i = '0;
    #1;
    check_reset_outputs("reset");
    @(posedge clk_i); @(posedge clk_i);
    #2 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // ADDI x1,x0,-1
    step(1'b1, 32'hFFF00093, 32'h100, 1'b1, 1'b0, acc);
    check("addi_valid", 128'(out_valid_o), 128'(1));
    check("addi_opimm", 128'(out_op_o.op_imm), 128'(1));
    check("addi_rd", 128'(out_field_o.rd), 128'(1));
    check("addi_imm", 128'(out_imm_o), 128'(32'hFFFF_FFFF));
    check("addi_pc", 128'(out_pc_o), 128'(32'h100));
    idle(2);

    // Three back-to-back inputs with downstream stalled.
    step(1'b1, 32'h00208133, 32'h200, 1'b0, 1'b0, acc);
    step(1'b1, 32'h00412183, 32'h204, 1'b0, 1'b0, acc);
    check("bp_ready_low", 128'(in_ready_o), 128'(0));
    step(1'b1, 32'h123452B7, 32'h208, 1'b0, 1'b0, acc);
    check("bp_third_held", 128'(acc), 128'(0));
    tries = 0;
    while (!acc && tries < 5) begin
      step(1'b1, 32'h123452B7, 32'h208, 1'b1, 1'b0, acc);
      tries++;
    end
    check("bp_third_taken", 128'(acc), 128'(1));
    idle(4);

    // BEQ imm -8, JAL imm +2048
    step(1'b1, 32'hFE000CE3, 32'h300, 1'b1, 1'b0, acc);
    check("beq_branch", 128'(out_op_o.branch), 128'(1));
    check("beq_imm", 128'(out_imm_o), 128'(32'hFFFF_FFF8));
    step(1'b1, 32'h0010006F, 32'h304, 1'b1, 1'b0, acc);
    check("jal_jal", 128'(out_op_o.jal), 128'(1));
    check("jal_imm", 128'(out_imm_o), 128'(32'h0000_0800));
    idle(2);

    // Flush while FULL with a concurrent input.
    step(1'b1, 32'h00100093, 32'h400, 1'b0, 1'b0, acc);
    step(1'b1, 32'h00200093, 32'h404, 1'b0, 1'b0, acc);
    step(1'b1, 32'h00300093, 32'h408, 1'b0, 1'b1, acc);
    check("flush_valid", 128'(out_valid_o), 128'(0));
    check("flush_ready", 128'(in_ready_o), 128'(1));
    idle(3);

    // Illegal-instruction inputs.
    step(1'b1, 32'h0000001B, 32'h500, 1'b1, 1'b0, acc);
    check("ill_opimm32", 128'(out_illegal_o), 128'(ILL_EN));
    step(1'b1, 32'h00000000, 32'h504, 1'b1, 1'b0, acc);
    check("ill_zero", 128'(out_illegal_o), 128'(ILL_EN));
    idle(2);

    // Asynchronous reset while FULL, between clock edges.
    step(1'b1, 32'h00500113, 32'h600, 1'b0, 1'b0, acc);
    step(1'b1, 32'h00600113, 32'h604, 1'b0, 1'b0, acc);
    check("pre_reset_full", 128'(in_ready_o), 128'(0));
    in_valid_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    q.delete();
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    idle(3);

    // Randomized traffic; upstream holds an offered instruction until accepted.
    have = 1'b0;
    pi   = '0;
    ppc  = 32'h1000;
    for (int c = 0; c < 800; c++) begin
      if (!have) begin
        have = ($urandom_range(0, 3) != 0);
        pi   = rand_instr();
      end
      step(have, pi, ppc, ($urandom_range(0, 2) != 0), ($urandom_range(0, 24) == 0), acc);
      if (acc || flush_i) begin
        have = 1'b0;
        ppc  = ppc + 4;
      end
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
